// File: rtl/wb_regfile_dump_pkg.sv
// Shared definitions for the write-back register file and its debug dump engine.
package wb_regfile_dump_pkg;
  localparam int unsigned NREGS          = 32;
  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned BYTE_CNT_W     = $clog2(BYTES_PER_WORD);
  localparam int unsigned REG_CNT_W      = $clog2(NREGS);

  typedef enum logic [1:0] {
    DUMP_IDLE = 2'd0,
    DUMP_SEND = 2'd1,
    DUMP_DONE = 2'd2
  } dump_state_e;
endpackage

// File: rtl/wb_regfile_dump_serializer.sv
// Streams every register, LSB byte first, over a valid/ready byte handshake.
module regdump_serializer
  import wb_regfile_dump_pkg::*;
#(
  parameter int unsigned NWORDS = NREGS,
  parameter int unsigned AW     = REG_CNT_W
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          start_i,
  input  logic                          byte_ready_i,
  input  logic [8*BYTES_PER_WORD-1:0]   reg_data_i,
  output logic [AW-1:0]                 reg_addr_o,
  output logic [7:0]                    byte_o,
  output logic                          byte_valid_o,
  output logic                          busy_o,
  output logic                          done_o
);
  dump_state_e           state_q, state_d;
  logic [AW-1:0]         reg_q, reg_d;
  logic [BYTE_CNT_W-1:0] byte_q, byte_d;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= DUMP_IDLE;
      reg_q   <= '0;
      byte_q  <= '0;
    end else begin
      state_q <= state_d;
      reg_q   <= reg_d;
      byte_q  <= byte_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    reg_d        = reg_q;
    byte_d       = byte_q;
    byte_valid_o = 1'b0;
    done_o       = 1'b0;
    case (state_q)
      DUMP_IDLE: begin
        if (start_i) begin
          state_d = DUMP_SEND;
          reg_d   = '0;
          byte_d  = '0;
        end
      end
      DUMP_SEND: begin
        byte_valid_o = 1'b1;
        if (byte_ready_i) begin
          if (byte_q == BYTE_CNT_W'(BYTES_PER_WORD - 1)) begin
            byte_d = '0;
            if (reg_q == AW'(NWORDS - 1)) state_d = DUMP_DONE;
            else                          reg_d   = reg_q + AW'(1);
          end else begin
            byte_d = byte_q + BYTE_CNT_W'(1);
          end
        end
      end
      DUMP_DONE: begin
        done_o  = 1'b1;
        state_d = DUMP_IDLE;
      end
      default: state_d = DUMP_IDLE;
    endcase
  end

  // Register contents are frozen while halted, so the byte holds steady during stalls.
  assign byte_o     = byte_valid_o ? reg_data_i[{byte_q, 3'b000} +: 8] : '0;
  assign reg_addr_o = reg_q;
  assign busy_o     = (state_q != DUMP_IDLE);
endmodule

// File: rtl/wb_regfile_dump.sv
// Write-back stage: value select, register file with bypassed read ports, halt latch, debug dump.
module wb_regfile_dump #(
  parameter int unsigned NBITS = 32,
  parameter int unsigned RBITS = 5,
  parameter int unsigned NREGS = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [NBITS-1:0] WB_result,
  input  logic [NBITS-1:0] WB_data,
  input  logic [RBITS-1:0] WB_rd,
  input  logic             WB_regwrite,
  input  logic             WB_memtoreg,
  input  logic             WB_haltflag,
  input  logic [RBITS-1:0] i_rs_addr,
  input  logic [RBITS-1:0] i_rt_addr,
  output logic [NBITS-1:0] o_rs_data,
  output logic [NBITS-1:0] o_rt_data,
  output logic [NBITS-1:0] o_wb_value,
  output logic             o_halted,
  input  logic             i_dump_req,
  input  logic             i_byte_ready,
  output logic [7:0]       o_byte,
  output logic             o_byte_valid,
  output logic             o_dump_busy,
  output logic             o_dump_done
);
  import wb_regfile_dump_pkg::*;

  logic [NBITS-1:0] regs_q [NREGS];
  logic             halted_q;
  logic             we;
  logic [RBITS-1:0] dump_addr;
  logic [NBITS-1:0] dump_data;

  assign o_wb_value = WB_memtoreg ? WB_data : WB_result;
  assign we         = WB_regwrite && (WB_rd != '0) && !halted_q;

  // Entry 0 is never written, so it reads as zero straight from the array.
  assign o_rs_data  = (we && (i_rs_addr == WB_rd)) ? o_wb_value : regs_q[i_rs_addr];
  assign o_rt_data  = (we && (i_rt_addr == WB_rd)) ? o_wb_value : regs_q[i_rt_addr];
  assign o_halted   = halted_q;
  assign dump_data  = regs_q[dump_addr];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int unsigned i = 0; i < NREGS; i++) regs_q[i] <= '0;
      halted_q <= 1'b0;
    end else begin
      if (WB_haltflag) halted_q <= 1'b1;
      if (we) regs_q[WB_rd] <= o_wb_value;
    end
  end

  regdump_serializer #(
    .NWORDS (NREGS),
    .AW     (RBITS)
  ) u_serializer (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .start_i      (i_dump_req && halted_q),
    .byte_ready_i (i_byte_ready),
    .reg_data_i   (dump_data),
    .reg_addr_o   (dump_addr),
    .byte_o       (o_byte),
    .byte_valid_o (o_byte_valid),
    .busy_o       (o_dump_busy),
    .done_o       (o_dump_done)
  );
endmodule
